// File: rtl/sdram_arbiter_if.sv
// Handshake bundle between the SDRAM arbiter, its clients
// and the init/refresh/read/write engines.
interface sdram_arbiter_if;
  logic ird_req;
  logic iwr_req;
  logic ord_done;
  logic owr_done;
  logic oinit_done;
  logic oerr;
  logic oreq_init;
  logic oenb_init;
  logic ifin_init;
  logic oreq_ref;
  logic oenb_ref;
  logic ifin_ref;
  logic oreq_rd;
  logic oenb_rd;
  logic ifin_rd;
  logic oreq_wr;
  logic oenb_wr;
  logic ifin_wr;

  modport master (
    input  ird_req, iwr_req,
    input  ifin_init, ifin_ref,
    input  ifin_rd, ifin_wr,
    output ord_done, owr_done,
    output oinit_done, oerr,
    output oreq_init, oenb_init,
    output oreq_ref, oenb_ref,
    output oreq_rd, oenb_rd,
    output oreq_wr, oenb_wr
  );

  modport slave (
    output ird_req, iwr_req,
    output ifin_init, ifin_ref,
    output ifin_rd, ifin_wr,
    input  ord_done, owr_done,
    input  oinit_done, oerr,
    input  oreq_init, oenb_init,
    input  oreq_ref, oenb_ref,
    input  oreq_rd, oenb_rd,
    input  oreq_wr, oenb_wr
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM sequencer: power-up wait, init, periodic refresh
// and round-robin client access to the read/write engines.
module sdram_arbiter #(
  parameter int INIT_WAIT        = 10000,
  parameter int REFRESH_INTERVAL = 780,
  parameter int TIMEOUT          = 1023,
  parameter int CTR_WIDTH        = 16
) (
  input logic             iclk,
  input logic             ireset,
  sdram_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    REFRESH,
    READ,
    WRITE
  } state_t;

  localparam logic [CTR_WIDTH-1:0] WAIT_LAST =
    CTR_WIDTH'(INIT_WAIT - 1);
  localparam logic [CTR_WIDTH-1:0] REF_LAST =
    CTR_WIDTH'(REFRESH_INTERVAL - 1);
  localparam logic [CTR_WIDTH-1:0] WDOG_LAST =
    CTR_WIDTH'(TIMEOUT - 1);

  state_t               state;
  logic [CTR_WIDTH-1:0] wait_ctr;
  logic [CTR_WIDTH-1:0] ref_ctr;
  logic [CTR_WIDTH-1:0] wdog;
  logic                 ref_pending;
  logic                 last_wr;

  logic fin;
  logic ref_wrap;
  logic ref_take;
  logic wdog_hit;
  logic pick_rd;
  logic pick_wr;

  // Only the granted engine's finish is honoured.
  always_comb begin
    fin = 1'b0;
    unique case (state)
      INIT:    fin = bus.ifin_init;
      REFRESH: fin = bus.ifin_ref;
      READ:    fin = bus.ifin_rd;
      WRITE:   fin = bus.ifin_wr;
      default: fin = 1'b0;
    endcase
  end

  always_comb begin
    ref_wrap = bus.oinit_done &&
               (ref_ctr == REF_LAST);
    ref_take = (state == IDLE) && ref_pending;
    wdog_hit = (wdog == WDOG_LAST);
    pick_rd  = bus.ird_req &&
               (!bus.iwr_req || last_wr);
    pick_wr  = bus.iwr_req &&
               (!bus.ird_req || !last_wr);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state          <= PWR_WAIT;
      wait_ctr       <= '0;
      ref_ctr        <= '0;
      wdog           <= '0;
      ref_pending    <= 1'b0;
      last_wr        <= 1'b1;
      bus.ord_done   <= 1'b0;
      bus.owr_done   <= 1'b0;
      bus.oinit_done <= 1'b0;
      bus.oerr       <= 1'b0;
      bus.oreq_init  <= 1'b0;
      bus.oenb_init  <= 1'b0;
      bus.oreq_ref   <= 1'b0;
      bus.oenb_ref   <= 1'b0;
      bus.oreq_rd    <= 1'b0;
      bus.oenb_rd    <= 1'b0;
      bus.oreq_wr    <= 1'b0;
      bus.oenb_wr    <= 1'b0;
    end else begin
      bus.oreq_init <= 1'b0;
      bus.oreq_ref  <= 1'b0;
      bus.oreq_rd   <= 1'b0;
      bus.oreq_wr   <= 1'b0;
      bus.ord_done  <= 1'b0;
      bus.owr_done  <= 1'b0;
      wdog          <= wdog + 1'b1;

      if (ref_wrap)
        ref_ctr <= '0;
      else if (bus.oinit_done)
        ref_ctr <= ref_ctr + 1'b1;

      // A wrap coinciding with the take starts a new period.
      if (ref_wrap) begin
        ref_pending <= 1'b1;
        if (ref_pending && !ref_take)
          bus.oerr <= 1'b1;
      end else if (ref_take) begin
        ref_pending <= 1'b0;
      end

      unique case (state)
        PWR_WAIT: begin
          if (wait_ctr == WAIT_LAST) begin
            state         <= INIT;
            wait_ctr      <= '0;
            wdog          <= '0;
            bus.oreq_init <= 1'b1;
            bus.oenb_init <= 1'b1;
          end else begin
            wait_ctr <= wait_ctr + 1'b1;
          end
        end
        INIT: begin
          if (fin) begin
            state          <= IDLE;
            bus.oenb_init  <= 1'b0;
            bus.oinit_done <= 1'b1;
          end else if (wdog_hit) begin
            state         <= PWR_WAIT;
            bus.oenb_init <= 1'b0;
            bus.oerr      <= 1'b1;
          end
        end
        IDLE: begin
          wdog <= '0;
          if (ref_pending) begin
            state        <= REFRESH;
            bus.oreq_ref <= 1'b1;
            bus.oenb_ref <= 1'b1;
          end else if (pick_rd) begin
            state       <= READ;
            last_wr     <= 1'b0;
            bus.oreq_rd <= 1'b1;
            bus.oenb_rd <= 1'b1;
          end else if (pick_wr) begin
            state       <= WRITE;
            last_wr     <= 1'b1;
            bus.oreq_wr <= 1'b1;
            bus.oenb_wr <= 1'b1;
          end
        end
        REFRESH: begin
          if (fin || wdog_hit) begin
            state        <= IDLE;
            bus.oenb_ref <= 1'b0;
            if (!fin)
              bus.oerr <= 1'b1;
          end
        end
        READ: begin
          if (fin || wdog_hit) begin
            state        <= IDLE;
            bus.oenb_rd  <= 1'b0;
            bus.ord_done <= fin;
            if (!fin)
              bus.oerr <= 1'b1;
          end
        end
        WRITE: begin
          if (fin || wdog_hit) begin
            state        <= IDLE;
            bus.oenb_wr  <= 1'b0;
            bus.owr_done <= fin;
            if (!fin)
              bus.oerr <= 1'b1;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule
